// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, state encoding and circular-index helper for the serial FIR
package fir_pkg;
    localparam int NTAPS = 17;
    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int AW    = 24;
    localparam int IW    = 5;

    localparam logic [IW-1:0] LAST = IW'(NTAPS - 1);

    localparam logic signed [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // (base - k) mod NTAPS; the 5-bit wrap of base + NTAPS - k is exact since both are < NTAPS
    function automatic logic [IW-1:0] tap_idx(input logic [IW-1:0] base, input logic [IW-1:0] k);
        return (base >= k) ? base - k : base + IW'(NTAPS) - k;
    endfunction
endpackage

// File: rtl/fir_mac.sv
// fir_mac: registered signed multiply-accumulate; FIR_SAT_EN widens the accumulator and clamps the result
module fir_mac
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [CW-1:0] coef,
    input  logic signed [DW-1:0] smp,
    output logic signed [AW-1:0] acc_o
);
`ifdef FIR_SAT_EN
    localparam int XW = AW + 5;
`else
    localparam int XW = AW;
`endif

    logic signed [XW-1:0]    acc_q, acc_d, sum;
    logic signed [CW+DW-1:0] prod;

    // acc_o carries the running sum including this cycle's product, so the last tap lands in data_o directly
    always_comb begin
        prod  = coef * smp;
        sum   = acc_q + XW'(prod);
        acc_d = clr ? '0 : en ? sum : acc_q;
`ifdef FIR_SAT_EN
        acc_o = (sum > XW'(SAT_MAX)) ? SAT_MAX : (sum < XW'(SAT_MIN)) ? SAT_MIN : AW'(sum);
`else
        acc_o = sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end
endmodule

// File: rtl/fir_serial_ctrl.sv
// fir_serial_ctrl: 17-tap FIR sequencer sharing one MAC over a circular sample buffer (FIR_SAT_EN selects saturation)
module fir_serial_ctrl
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 clr_i,
    input  logic                 coef_we,
    input  logic [IW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic signed [AW-1:0] data_o,
    output logic                 valid_o
);
    state_e               state_q, state_d;
    logic signed [DW-1:0] buf_q [NTAPS];
    logic signed [DW-1:0] buf_d [NTAPS];
    logic signed [CW-1:0] coef_q [NTAPS];
    logic signed [CW-1:0] coef_d [NTAPS];
    logic [IW-1:0]        wp_q, wp_d, base_q, base_d, k_q, k_d;
    logic signed [AW-1:0] data_q, data_d, mac_res;
    logic                 valid_q, valid_d, mac_clr, mac_en;

    assign ready_o = (state_q == IDLE) && !rst;
    assign data_o  = data_q;
    assign valid_o = valid_q;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        coef_d  = coef_q;
        wp_d    = wp_q;
        base_d  = base_q;
        k_d     = k_q;
        data_d  = data_q;
        valid_d = 1'b0;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        if (coef_we && ready_o && coef_addr <= LAST) coef_d[coef_addr] = coef_data;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = FLUSH;
                    k_d     = '0;
                end else if (valid_i) begin
                    buf_d[wp_q] = data_i;
                    base_d      = wp_q;
                    wp_d        = (wp_q == LAST) ? '0 : wp_q + IW'(1);
                    mac_clr     = 1'b1;
                    k_d         = '0;
                    state_d     = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                k_d    = (k_q == LAST) ? '0 : k_q + IW'(1);
                if (k_q == LAST) begin
                    data_d  = mac_res;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                buf_d[k_q] = '0;
                k_d        = (k_q == LAST) ? '0 : k_q + IW'(1);
                if (k_q == LAST) begin
                    wp_d    = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    fir_mac u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr   (mac_clr),
        .en    (mac_en),
        .coef  (coef_q[k_q]),
        .smp   (buf_q[tap_idx(base_q, k_q)]),
        .acc_o (mac_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '{default: '0};
            coef_q  <= '{default: '0};
            wp_q    <= '0;
            base_q  <= '0;
            k_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            coef_q  <= coef_d;
            wp_q    <= wp_d;
            base_q  <= base_d;
            k_q     <= k_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
endmodule
